wb_ram_responder: RTL



---
 rtl/wb_ram_pkg.sv | 15 +
 rtl/wb_bram.sv | 48 ++++
 rtl/wb_ram_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/wb_ram_pkg.sv
// Shared types and defaults for the Wishbone RAM responder and its BRAM.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
    localparam int          DEF_DEPTH     = 1024;
    localparam int          DEF_DELAYS    = 10;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/wb_bram.sv
// Single-port DEPTHx32 block RAM with byte write enables and a registered read port.
module wb_bram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];
    logic [31:0] dout_q, dout_d;

    // Storage is never reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    // The read register only moves on reads, so writes leave the last read data visible.
    always_comb begin
        dout_d = dout_q;
        if (en && !we) begin
            dout_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic responder: decodes a fixed window, waits DELAYS cycles per access,
// then commits to the BRAM and acknowledges for one cycle.
module wb_ram_responder
    import wb_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int          DELAYS    = DEF_DELAYS
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [32:0]     WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0]     WIN_HI = WIN_LO + 33'(4 * DEPTH);
    // cnt holds the number of WAIT cycles still to spend before the commit edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DELAYS >= 2) ? DELAYS - 2 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             req;
    logic             hit;
    logic             mem_en;
    logic [32:0]      adr_ext;
    logic [AW-1:0]    word_idx;

    assign req     = wbs_stb_i & wbs_cyc_i;
    assign adr_ext = {1'b0, wbs_adr_i};
    assign hit     = req && (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
    // The window base is word aligned, so subtracting the word fields gives the offset.
    assign word_idx = wbs_adr_i[AW+1:2] - BASE_ADDR[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (DELAYS == 1) begin
                        state_d = ACK;
                        mem_en  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                    mem_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign wbs_ack_o = ack_q;

    // Read data comes straight from the BRAM read register, loaded on the commit edge.
    wb_bram #(
        .DEPTH(DEPTH)
    ) u_bram (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .en  (mem_en),
        .we  (wbs_we_i),
        .be  (wbs_sel_i),
        .addr(word_idx),
        .din (wbs_dat_i),
        .dout(wbs_dat_o)
    );

endmodule
